pc_gen_ras: RTL and testbench

//  Parametrised fetch-stage PC generator for the 3-stage RISC-V pipeline.

---
 rtl/rv_fetch_pkg.sv | 25 ++
 rtl/ras_stack.sv | 59 +++++
 rtl/pc_gen_ras.sv | 100 ++++++++++
 tb/tb_pc_gen_ras.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: next-PC source select and RISC-V
// call/return decode constants used to drive the return-address stack.
package rv_fetch_pkg;

    typedef enum logic [2:0] {
        PC_SEL_TRAP,
        PC_SEL_MRET,
        PC_SEL_REDIR,
        PC_SEL_HOLD,
        PC_SEL_RAS,
        PC_SEL_SEQ
    } pc_sel_e;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    // Link registers per the RISC-V return-address hint convention.
    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: pushes beyond RAS_DEPTH overwrite the
// oldest entry while the count saturates, so deep call chains lose the bottom.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_clear,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_push_addr,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(RAS_DEPTH);

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_top;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   w_top_inc;
    logic            w_pop;

    assign w_top_inc = r_top + 1'b1;
    assign w_pop     = i_pop && !o_empty;
    assign o_top     = r_mem[r_top];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == COUNT_MAX);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_top   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (i_push && w_pop) begin
            // Return and call in one instruction: swap the top entry in place.
            r_mem[r_top] <= i_push_addr;
        end else if (i_push) begin
            r_top            <= w_top_inc;
            r_mem[w_top_inc] <= i_push_addr;
            if (r_count != COUNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_pop) begin
            r_top   <= r_top - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch-stage PC generator: fixed-priority next-PC mux and PC register,
// with a return-address stack that predicts decoded returns early.
module pc_gen_ras
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4,
    parameter int              ILEN_B    = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_if_ready,
    input  logic            i_trap_taken,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_mret_taken,
    input  logic [XLEN-1:0] i_epc,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_call_push,
    input  logic [XLEN-1:0] i_call_ret_addr,
    input  logic            i_ret_pop,
    output logic [XLEN-1:0] o_pc,
    output logic            o_pc_valid,
    output logic            o_ras_pred,
    output logic            o_ras_empty,
    output logic            o_ras_full
);

    localparam logic [XLEN-1:0] W_ILEN     = XLEN'(ILEN_B);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(W_ILEN - 1'b1);

    pc_sel_e         w_sel;
    logic [XLEN-1:0] w_next_raw;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_pop_ok;
    logic            w_ras_upd;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_ras_pred;

    assign w_ras_pop_ok = i_ret_pop && !o_ras_empty;

    always_comb begin
        w_sel = PC_SEL_SEQ;
        if (i_trap_taken)                 w_sel = PC_SEL_TRAP;
        else if (i_mret_taken)            w_sel = PC_SEL_MRET;
        else if (i_redirect)              w_sel = PC_SEL_REDIR;
        else if (i_stall || !i_if_ready)  w_sel = PC_SEL_HOLD;
        else if (w_ras_pop_ok)            w_sel = PC_SEL_RAS;
    end

    always_comb begin
        w_next_raw = r_pc + W_ILEN;
        case (w_sel)
            PC_SEL_TRAP:  w_next_raw = i_trap_vec;
            PC_SEL_MRET:  w_next_raw = i_epc;
            PC_SEL_REDIR: w_next_raw = i_redirect_pc;
            PC_SEL_HOLD:  w_next_raw = r_pc;
            PC_SEL_RAS:   w_next_raw = w_ras_top;
            default:      w_next_raw = r_pc + W_ILEN;
        endcase
    end

    // Only a decode slot that actually advances fetch may touch the stack.
    assign w_ras_upd = (w_sel == PC_SEL_RAS) || (w_sel == PC_SEL_SEQ);

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_sel == PC_SEL_TRAP),
        .i_push      (i_call_push && w_ras_upd),
        .i_pop       (w_ras_pop_ok && w_ras_upd),
        .i_push_addr (i_call_ret_addr),
        .o_top       (w_ras_top),
        .o_empty     (o_ras_empty),
        .o_full      (o_ras_full)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc       <= RESET_VEC;
            r_pc_valid <= 1'b0;
            r_ras_pred <= 1'b0;
        end else begin
            r_pc       <= w_next_raw & ALIGN_MASK;
            r_pc_valid <= 1'b1;
            r_ras_pred <= (w_sel == PC_SEL_RAS);
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_valid = r_pc_valid;
    assign o_ras_pred = r_ras_pred;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: each task drives one scenario and checks
// the registered outputs one time unit after the clock edge.
module tb_pc_gen_ras;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        if_ready = 1'b1;
    logic        trap_taken = 1'b0;
    logic [31:0] trap_vec = '0;
    logic        mret_taken = 1'b0;
    logic [31:0] epc = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        call_push = 1'b0;
    logic [31:0] call_ret_addr = '0;
    logic        ret_pop = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        ras_pred;
    logic        ras_empty;
    logic        ras_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen_ras #(
        .XLEN      (32),
        .RESET_VEC (32'h0),
        .RAS_DEPTH (4),
        .ILEN_B    (4)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_stall         (stall),
        .i_if_ready      (if_ready),
        .i_trap_taken    (trap_taken),
        .i_trap_vec      (trap_vec),
        .i_mret_taken    (mret_taken),
        .i_epc           (epc),
        .i_redirect      (redirect),
        .i_redirect_pc   (redirect_pc),
        .i_call_push     (call_push),
        .i_call_ret_addr (call_ret_addr),
        .i_ret_pop       (ret_pop),
        .o_pc            (pc),
        .o_pc_valid      (pc_valid),
        .o_ras_pred      (ras_pred),
        .o_ras_empty     (ras_empty),
        .o_ras_full      (ras_full)
    );

    always @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown({stall, if_ready, trap_taken, mret_taken, redirect, call_push, ret_pop}))
                else $error("control input is X");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc pc=%h exp=%h", pc, 32'h0); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_pred !== 1'b0)
            begin errors++; $display("FAIL reset_ras empty=%b full=%b pred=%b exp 1/0/0", ras_empty, ras_full, ras_pred); end
        step();
        step();
        reset = 1'b0;
        checks++; if (pc !== 32'h0 || pc_valid !== 1'b0) begin errors++; $display("FAIL release_pc pc=%h valid=%b exp 0/0", pc, pc_valid); end
        step();
        checks++; if (pc !== 32'h4 || pc_valid !== 1'b1) begin errors++; $display("FAIL seq_4 pc=%h valid=%b exp 4/1", pc, pc_valid); end
        step();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_8 pc=%h exp=%h", pc, 32'h8); end
        step();
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_c pc=%h exp=%h", pc, 32'hC); end
    endtask

    task automatic test_stall_redirect();
        redirect = 1'b1; redirect_pc = 32'h10;
        step();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL redir_10 pc=%h exp=%h", pc, 32'h10); end
        redirect = 1'b0; stall = 1'b1;
        step();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold1 pc=%h exp=%h", pc, 32'h10); end
        step();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold2 pc=%h exp=%h", pc, 32'h10); end
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL redir_over_stall pc=%h exp=%h", pc, 32'h200); end
        redirect = 1'b0; stall = 1'b0; if_ready = 1'b0;
        step();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL not_ready_hold pc=%h exp=%h", pc, 32'h200); end
        if_ready = 1'b1;
        step();
        checks++; if (pc !== 32'h204) begin errors++; $display("FAIL ready_resume pc=%h exp=%h", pc, 32'h204); end
    endtask

    task automatic test_priority();
        call_push = 1'b1; call_ret_addr = 32'h104;
        step();
        checks++; if (pc !== 32'h208 || ras_empty !== 1'b0) begin errors++; $display("FAIL prio_push pc=%h empty=%b exp 208/0", pc, ras_empty); end
        trap_taken = 1'b1; trap_vec = 32'h82;
        mret_taken = 1'b1; epc = 32'h300;
        redirect = 1'b1; redirect_pc = 32'h400;
        ret_pop = 1'b1; stall = 1'b1;
        step();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL trap_wins pc=%h exp=%h", pc, 32'h80); end
        checks++; if (ras_empty !== 1'b1 || ras_pred !== 1'b0) begin errors++; $display("FAIL trap_clear empty=%b pred=%b exp 1/0", ras_empty, ras_pred); end
        trap_taken = 1'b0; call_push = 1'b0; ret_pop = 1'b0;
        step();
        checks++; if (pc !== 32'h300) begin errors++; $display("FAIL mret_wins pc=%h exp=%h", pc, 32'h300); end
        mret_taken = 1'b0;
        step();
        checks++; if (pc !== 32'h400) begin errors++; $display("FAIL redir_wins pc=%h exp=%h", pc, 32'h400); end
        redirect = 1'b0; stall = 1'b0;
    endtask

    task automatic test_ras_basic();
        call_push = 1'b1; call_ret_addr = 32'h104;
        step();
        checks++; if (pc !== 32'h404) begin errors++; $display("FAIL push1_seq pc=%h exp=%h", pc, 32'h404); end
        call_ret_addr = 32'h208;
        step();
        checks++; if (pc !== 32'h408) begin errors++; $display("FAIL push2_seq pc=%h exp=%h", pc, 32'h408); end
        call_push = 1'b0; ret_pop = 1'b1;
        step();
        checks++; if (pc !== 32'h208 || ras_pred !== 1'b1) begin errors++; $display("FAIL pop1 pc=%h pred=%b exp 208/1", pc, ras_pred); end
        step();
        checks++; if (pc !== 32'h104 || ras_pred !== 1'b1) begin errors++; $display("FAIL pop2 pc=%h pred=%b exp 104/1", pc, ras_pred); end
        step();
        checks++; if (pc !== 32'h108 || ras_pred !== 1'b0 || ras_empty !== 1'b1)
            begin errors++; $display("FAIL pop_empty pc=%h pred=%b empty=%b exp 108/0/1", pc, ras_pred, ras_empty); end
        ret_pop = 1'b0;
    endtask

    task automatic test_ras_wrap();
        logic [31:0] addrs [5];
        logic [31:0] exp_pc;
        addrs[0] = 32'h1000; addrs[1] = 32'h2000; addrs[2] = 32'h3000;
        addrs[3] = 32'h4000; addrs[4] = 32'h5000;
        exp_pc = 32'h108;
        call_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            call_ret_addr = addrs[i];
            step();
            exp_pc = exp_pc + 32'h4;
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL wrap_push%0d pc=%h exp=%h", i, pc, exp_pc); end
            if (i >= 3) begin
                checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL wrap_full%0d got=%b exp=1", i, ras_full); end
            end
        end
        call_push = 1'b0; ret_pop = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            step();
            checks++; if (pc !== addrs[i] || ras_pred !== 1'b1)
                begin errors++; $display("FAIL wrap_pop%0d pc=%h pred=%b exp=%h/1", i, pc, ras_pred, addrs[i]); end
        end
        step();
        checks++; if (pc !== 32'h2004 || ras_pred !== 1'b0 || ras_empty !== 1'b1)
            begin errors++; $display("FAIL wrap_lost pc=%h pred=%b empty=%b exp 2004/0/1", pc, ras_pred, ras_empty); end
        ret_pop = 1'b0;
    endtask

    task automatic test_push_pop();
        call_push = 1'b1; call_ret_addr = 32'h600;
        step();
        checks++; if (pc !== 32'h2008) begin errors++; $display("FAIL pp_push pc=%h exp=%h", pc, 32'h2008); end
        call_ret_addr = 32'h700; ret_pop = 1'b1;
        step();
        checks++; if (pc !== 32'h600 || ras_pred !== 1'b1 || ras_empty !== 1'b0)
            begin errors++; $display("FAIL pp_swap pc=%h pred=%b empty=%b exp 600/1/0", pc, ras_pred, ras_empty); end
        call_push = 1'b0;
        step();
        checks++; if (pc !== 32'h700 || ras_empty !== 1'b1) begin errors++; $display("FAIL pp_replaced pc=%h empty=%b exp 700/1", pc, ras_empty); end
        call_push = 1'b1; call_ret_addr = 32'h800;
        step();
        checks++; if (pc !== 32'h704 || ras_pred !== 1'b0 || ras_empty !== 1'b0)
            begin errors++; $display("FAIL pp_empty pc=%h pred=%b empty=%b exp 704/0/0", pc, ras_pred, ras_empty); end
        call_push = 1'b0; stall = 1'b1;
        step();
        checks++; if (pc !== 32'h704 || ras_empty !== 1'b0) begin errors++; $display("FAIL pop_stalled pc=%h empty=%b exp 704/0", pc, ras_empty); end
        stall = 1'b0;
        step();
        checks++; if (pc !== 32'h800 || ras_empty !== 1'b1) begin errors++; $display("FAIL pop_after_stall pc=%h empty=%b exp 800/1", pc, ras_empty); end
        ret_pop = 1'b0;
    endtask

    task automatic test_wrap_align_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL redir_top pc=%h exp=%h", pc, 32'hFFFF_FFFC); end
        redirect = 1'b0;
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap pc=%h exp=%h", pc, 32'h0); end
        redirect = 1'b1; redirect_pc = 32'h203;
        step();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL align pc=%h exp=%h", pc, 32'h200); end
        redirect = 1'b0; call_push = 1'b1; call_ret_addr = 32'h500;
        step();
        checks++; if (pc !== 32'h204 || ras_empty !== 1'b0) begin errors++; $display("FAIL pre_reset pc=%h empty=%b exp 204/0", pc, ras_empty); end
        call_push = 1'b0; ret_pop = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++; if (pc !== 32'h0 || ras_empty !== 1'b1 || pc_valid !== 1'b0 || ras_pred !== 1'b0)
            begin errors++; $display("FAIL async_reset pc=%h empty=%b valid=%b pred=%b exp 0/1/0/0", pc, ras_empty, pc_valid, ras_pred); end
        step();
        ret_pop = 1'b0; reset = 1'b0;
        step();
        checks++; if (pc !== 32'h4 || pc_valid !== 1'b1 || ras_empty !== 1'b1)
            begin errors++; $display("FAIL post_reset pc=%h valid=%b empty=%b exp 4/1/1", pc, pc_valid, ras_empty); end
    endtask

    initial begin
        test_reset();
        test_stall_redirect();
        test_priority();
        test_ras_basic();
        test_ras_wrap();
        test_push_pop();
        test_wrap_align_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
